// File: rtl/alu_muldiv.sv
// alu_muldiv -- MIPS execute-stage ALU with an iterative multiply/divide unit.
//
// Purpose:
//   Single-cycle combinational datapath (add/sub/logic/shift/compare, mfhi/mflo)
//   plus a sequential mult/multu/div/divu engine that owns the architectural
//   HI/LO registers.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   a, b              operands (rs, rt/immediate)
//   alu_op            00 add, 01 sub, 10 decode funct, 11 reserved (out = 0)
//   funct, shamt      MIPS funct field and shift amount
//   start             launch mult/div (alu_op=10, funct 24..27)
//   out, out_zero     combinational result and its zero flag
//   overflow          signed overflow for funct 32 (add) / 34 (sub) only
//   busy, done        mult/div in progress / one-cycle pulse when HI/LO written
//   hi, lo            architectural HI/LO registers
//   fsm_state         current mult/div FSM state (0 idle, 1 run, 2 fix)
//
// Handshake: start is accepted only on an edge where the FSM is idle and the
// op is a mul/div funct; otherwise it is dropped. busy is high from the edge
// after acceptance until the edge that writes HI/LO; done is high for exactly
// the one cycle following that write. Operands are latched at acceptance.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t state, state_nxt;

  // ---------------- combinational datapath ----------------
  logic [WIDTH-1:0] sum, diff;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (alu_op)
      2'b00: out = sum;
      2'b01: out = diff;
      2'b10: begin
        case (funct)
          6'd32, 6'd33: out = sum;
          6'd34, 6'd35: out = diff;
          6'd36:        out = a & b;
          6'd37:        out = a | b;
          6'd38:        out = a ^ b;
          6'd39:        out = ~(a | b);
          6'd42:        out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          6'd43:        out = {{(WIDTH-1){1'b0}}, (a < b)};
          6'd0:         out = a << shamt;
          6'd2:         out = a >> shamt;
          6'd3:         out = $signed(a) >>> shamt;
          6'd16:        out = hi;
          6'd18:        out = lo;
          default:      out = '0;
        endcase
        if (funct == 6'd32)
          overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (funct == 6'd34)
          overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: out = '0;
    endcase
  end

  assign out_zero = (out == '0);

  // ---------------- multiply / divide engine ----------------
  // acc holds {upper, lower}: for multiply {partial product, multiplier},
  // for divide {remainder, dividend/quotient}. opnd is multiplicand or divisor.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [SHW-1:0]     count;
  logic               is_mul, neg_q, neg_r;

  logic               launch, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;

  // funct 24..27 = 6'b0110xx; bit0 clear = signed, bit1 clear = multiply
  assign launch    = start && (alu_op == 2'b10) && (funct[5:2] == 4'b0110) && (state == S_IDLE);
  assign signed_op = ~funct[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;

  // One multiply step: conditional add of the multiplicand, then shift right.
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_add  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign mul_next = {mul_add, acc[WIDTH-1:1]};

  // One restoring-divide step. A plain >= compare (not the trial sign bit)
  // keeps a zero divisor well behaved: every quotient bit becomes 1 and the
  // remainder ends up equal to the dividend.
  logic [WIDTH:0]     div_shift, div_trial;
  logic               div_geq;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, opnd};
  assign div_geq   = (div_shift >= {1'b0, opnd});
  assign div_next  = div_geq ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                             : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  // Sign correction applied while in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_RUN;
      S_RUN:   if (count == SHW'(WIDTH-1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy      = (state != S_IDLE);
    fsm_state = state;
  end

  // datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      count  <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (launch) begin
          is_mul <= ~funct[1];
          // Divide by zero must leave the all-ones quotient un-negated.
          neg_q  <= (a_neg ^ b_neg) && (~funct[1] || (b != '0));
          neg_r  <= a_neg;
          acc    <= funct[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
          opnd   <= funct[1] ? b_abs : a_abs;
          count  <= '0;
        end
        S_RUN: begin
          acc   <= is_mul ? mul_next : div_next;
          count <= count + 1'b1;
        end
        S_FIX: begin
          if (is_mul) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv -- self-checking bench for alu_muldiv (WIDTH = 32).
// Combinational results are checked directly; mult/div results are pushed to
// an expected queue at launch and popped when the DUT pulses done.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic        start;
  logic [31:0] out, hi, lo;
  logic        out_zero, overflow, busy, done;
  logic [1:0]  fsm_state;

  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;
  logic [31:0] model_hi, model_lo;
  int          vectors, miscompares, done_cnt;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alu_op(alu_op), .funct(funct),
    .shamt(shamt), .start(start), .out(out), .out_zero(out_zero),
    .overflow(overflow), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard: pop on done ----------------
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("hi", hi, sb_exp[63:32]);
        check("lo", lo, sb_exp[31:0]);
        model_hi = sb_exp[63:32];
        model_lo = sb_exp[31:0];
      end
    end
  end

  // ---------------- reference for random mult/div ----------------
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     sx, sy;
    logic [63:0] r;
    sx = x;
    sy = y;
    case (f)
      6'd24: begin p = longint'($signed(x)) * longint'($signed(y)); r = p; end
      6'd25: r = {32'b0, x} * {32'b0, y};
      6'd26: r = {32'(sx % sy), 32'(sx / sy)};
      default: r = {x % y, x / y};
    endcase
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic alu(input string tag, input logic [1:0] op, input logic [5:0] f,
                     input logic [4:0] sh, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e_out, input logic e_ov, input logic e_z);
    @(negedge clk);
    alu_op = op; funct = f; shamt = sh; a = x; b = y;
    #1;
    check(tag, out, e_out);
    check({tag, "_ov"}, overflow, e_ov);
    check({tag, "_z"}, out_zero, e_z);
  endtask

  // Launch a mult/div, optionally disturb it (second start, operand churn),
  // check mflo/mfhi while busy, busy length and a single done pulse.
  task automatic md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                    input logic [63:0] e, input bit disturb);
    int cycles;
    int d0;
    @(negedge clk);
    alu_op = 2'b10; funct = f; a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; funct = 6'd18; a = $urandom; b = $urandom;
    d0 = done_cnt;
    cycles = 0;
    while (busy && cycles < 100) begin
      start = 1'b0;
      if (cycles == 3) begin
        funct = 6'd18; #1; check("mflo_busy", out, model_lo);
      end else if (cycles == 4) begin
        funct = 6'd16; #1; check("mfhi_busy", out, model_hi);
      end else if (disturb && cycles == 5) begin
        start = 1'b1; funct = 6'd25; a = $urandom; b = $urandom;
      end else if (disturb) begin
        a = $urandom; b = $urandom;
      end
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", cycles, 33);
    check("done_pulse", done, 1);
    @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("done_low", done, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vectors = 0; miscompares = 0; done_cnt = 0;
    model_hi = '0; model_lo = '0;
    reset = 1'b1; start = 1'b0; alu_op = 2'b00; funct = 6'd0; shamt = 5'd0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;

    // combinational path
    alu("add_ovf", 2'b10, 6'd32, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0);
    alu("addu",    2'b10, 6'd33, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0);
    alu("sub_z",   2'b10, 6'd34, 5'd0, 32'd5, 32'd5, 32'h0, 1'b0, 1'b1);
    alu("sub_ovf", 2'b10, 6'd34, 5'd0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0);
    alu("subu",    2'b10, 6'd35, 5'd0, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0);
    alu("op_add",  2'b00, 6'd0, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1);
    alu("op_sub",  2'b01, 6'd34, 5'd0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b0);
    alu("op_rsv",  2'b11, 6'd32, 5'd0, 32'h12345678, 32'h1, 32'h0, 1'b0, 1'b1);
    alu("and",     2'b10, 6'd36, 5'd0, 32'hF0F0FF00, 32'hFF00F0F0, 32'hF000F000, 1'b0, 1'b0);
    alu("or",      2'b10, 6'd37, 5'd0, 32'hF0F00000, 32'h0000000F, 32'hF0F0000F, 1'b0, 1'b0);
    alu("xor",     2'b10, 6'd38, 5'd0, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0);
    alu("nor",     2'b10, 6'd39, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
    alu("slt",     2'b10, 6'd42, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0);
    alu("sltu",    2'b10, 6'd43, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1);
    alu("sra",     2'b10, 6'd3, 5'd4, 32'h80000000, 32'h0, 32'hF8000000, 1'b0, 1'b0);
    alu("srl",     2'b10, 6'd2, 5'd4, 32'h80000000, 32'h0, 32'h08000000, 1'b0, 1'b0);
    alu("sll",     2'b10, 6'd0, 5'd31, 32'h3, 32'h0, 32'h80000000, 1'b0, 1'b0);
    alu("f_mult",  2'b10, 6'd24, 5'd0, 32'h5, 32'h7, 32'h0, 1'b0, 1'b1);
    alu("f_undef", 2'b10, 6'd44, 5'd0, 32'h5, 32'h7, 32'h0, 1'b0, 1'b1);

    // start with a non-mul/div funct is ignored
    @(negedge clk);
    alu_op = 2'b10; funct = 6'd32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_bad_funct", busy, 0);

    // multiply / divide, constants
    md(6'd24, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB}, 1'b1);
    md(6'd25, 32'hFFFFFFFD, 32'd7, {32'h00000006, 32'hFFFFFFEB}, 1'b0);
    md(6'd26, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1);
    md(6'd27, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    md(6'd26, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b0);
    md(6'd26, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b0);
    md(6'd27, 32'h80000001, 32'd0, {32'h80000001, 32'hFFFFFFFF}, 1'b0);
    md(6'd26, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0);
    md(6'd24, 32'h80000000, 32'h80000000, {32'h40000000, 32'h0}, 1'b0);
    md(6'd26, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b0);

    // mfhi / mflo readout when idle
    alu("mfhi", 2'b10, 6'd16, 5'd0, 32'h0, 32'h0, model_hi, 1'b0, (model_hi == 32'h0));
    alu("mflo", 2'b10, 6'd18, 5'd0, 32'h0, 32'h0, model_lo, 1'b0, (model_lo == 32'h0));

    // random mult/div against the reference
    for (int i = 0; i < 8; i++) begin
      logic [5:0]  rf;
      logic [31:0] ra, rb;
      rf = 6'($urandom_range(24, 27));
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'h0 || rb == 32'hFFFFFFFF) rb = 32'd3;
      if (i[0]) rb = 32'($urandom_range(1, 300));
      md(rf, ra, rb, ref_md(rf, ra, rb), i[1]);
    end

    // reset in the middle of a divide
    begin
      int d0;
      @(negedge clk);
      alu_op = 2'b10; funct = 6'd26; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_hi", hi, 0);
      check("mid_rst_lo", lo, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_state", fsm_state, 0);
      @(negedge clk);
      reset = 1'b0;
      model_hi = '0;
      model_lo = '0;
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      check("no_done_after_rst", done_cnt - d0, 0);
      md(6'd27, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
